// File: rtl/countdown_timer_32_pkg.sv
// Shared definitions for the countdown_timer_32 block.
//   state_e      : timer FSM encoding (StIdle = 0, StRun = 1)
//   DefaultWidth : default counter / load-value width
//   CountZero    : zero constant for count compares
package countdown_timer_32_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [DefaultWidth-1:0] CountZero = '0;

endpackage

// File: rtl/countdown_timer_32_down_counter_core.sv
// Down-counter datapath for countdown_timer_32.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low clear
//   clr_i          : synchronous clear to zero (highest priority)
//   load_i         : parallel load of load_value_i
//   load_value_i   : value to load
//   dec_i          : decrement by one this cycle
//   count_o        : registered count
//   is_one_o       : combinational flag, count_o == 1
module countdown_timer_32_down_counter_core
  import countdown_timer_32_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             is_one_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer_32.sv
// Loadable down-counter / timer with one-shot and auto-reload modes.
// Ports:
//   clk_i          : rising-edge clock
//   rst_ni         : asynchronous active-low reset
//   load_i         : capture load_value_i and start (zero expires at once)
//   load_value_i   : number of enabled cycles to count
//   enable_i       : decrement this cycle while running
//   auto_reload_i  : on expiry reload the captured value and keep running
//   abort_i        : stop immediately, no done pulse
//   count_o        : remaining count
//   busy_o         : timer running
//   done_o         : one-cycle expiry pulse
module countdown_timer_32
  import countdown_timer_32_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  input  logic             auto_reload_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic             core_clr;
  logic             core_load;
  logic [WIDTH-1:0] core_load_value;
  logic             core_dec;
  logic             core_is_one;

  countdown_timer_32_down_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (core_clr),
    .load_i       (core_load),
    .load_value_i (core_load_value),
    .dec_i        (core_dec),
    .count_o      (count_o),
    .is_one_o     (core_is_one)
  );

  // Priority: abort > load > terminal/decrement > hold.
  always_comb begin
    state_d         = state_q;
    reload_d        = reload_q;
    done_d          = 1'b0;
    core_clr        = 1'b0;
    core_load       = 1'b0;
    core_load_value = load_value_i;
    core_dec        = 1'b0;

    if (abort_i) begin
      core_clr = 1'b1;
      state_d  = StIdle;
    end else if (load_i) begin
      if (load_value_i != WIDTH'(CountZero)) begin
        core_load = 1'b1;
        reload_d  = load_value_i;
        state_d   = StRun;
      end else begin
        // Zero-length timer expires on the load edge itself.
        core_clr = 1'b1;
        state_d  = StIdle;
        done_d   = 1'b1;
      end
    end else if (state_q == StRun && enable_i) begin
      if (core_is_one) begin
        done_d = 1'b1;
        if (auto_reload_i) begin
          core_load       = 1'b1;
          core_load_value = reload_q;
        end else begin
          core_clr = 1'b1;
          state_d  = StIdle;
        end
      end else begin
        core_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = done_q;

endmodule

// File: tb/tb_countdown_timer_32.sv
module tb_countdown_timer_32;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] lv;
  logic         en;
  logic         ar;
  logic         abort;
  logic [W-1:0] count_o;
  logic         busy_o;
  logic         done_o;

  countdown_timer_32 #(
    .WIDTH (W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_i        (load),
    .load_value_i  (lv),
    .enable_i      (en),
    .auto_reload_i (ar),
    .abort_i       (abort),
    .count_o       (count_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  // Reference model: remaining cycles, running flag, captured period, pulse.
  logic [W-1:0] m_count;
  logic [W-1:0] m_reload;
  logic         m_busy;
  logic         m_done;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    m_count  = '0;
    m_reload = '0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (abort) begin
      m_count = 0;
      m_busy  = 1'b0;
    end else if (load) begin
      if (lv == 0) begin
        m_count = 0;
        m_busy  = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_count  = lv;
        m_reload = lv;
        m_busy   = 1'b1;
      end
    end else if (m_busy && en) begin
      if (m_count == 1) begin
        m_done = 1'b1;
        if (ar) m_count = m_reload;
        else begin
          m_count = 0;
          m_busy  = 1'b0;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  // Apply inputs, clock one edge, update the model, return at the negedge.
  task automatic drive(input logic l, input logic [W-1:0] v, input logic e, input logic a,
                       input logic ab);
    load = l; lv = v; en = e; ar = a; abort = ab;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    load = 0; lv = 0; en = 0; ar = 0; abort = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (count_o !== 0 || busy_o !== 0 || done_o !== 0)
      $display("FAIL reset_initial: got count=%h busy=%b done=%b, want 0/0/0",
               count_o, busy_o, done_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // Mid-run asynchronous reset.
    drive(1, 32'h10, 1, 0, 0);
    n_checks++;
    if (count_o !== 32'h10 || busy_o !== 1)
      $display("FAIL reset_load: got count=%h busy=%b, want 00000010/1", count_o, busy_o);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (count_o !== 0 || busy_o !== 0 || done_o !== 0)
      $display("FAIL reset_async: got count=%h busy=%b done=%b, want 0/0/0",
               count_o, busy_o, done_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_one_shot();
    drive(1, 5, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (count_o !== m_count || busy_o !== m_busy || done_o !== m_done)
        $display("FAIL one_shot[%0d]: got %h/%b/%b, want %h/%b/%b", i, count_o, busy_o,
                 done_o, m_count, m_busy, m_done);
      else n_pass++;
      drive(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_pause();
    logic [4:0] pat;
    int done_at;
    pat = 5'b11001;  // applied LSB first: 1,0,0,1,1
    done_at = -1;
    drive(1, 3, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, pat[i], 0, 0);
      if (done_o === 1'b1) done_at = i;
      n_checks++;
      if (count_o !== m_count || busy_o !== m_busy || done_o !== m_done)
        $display("FAIL pause[%0d]: got %h/%b/%b, want %h/%b/%b", i, count_o, busy_o,
                 done_o, m_count, m_busy, m_done);
      else n_pass++;
    end
    // Continuous enable would expire on the 3rd edge; two stalls push it to the 5th.
    n_checks++;
    if (done_at !== 4) $display("FAIL pause_done_time: got %0d, want 4", done_at);
    else n_pass++;
  endtask

  task automatic test_auto_reload();
    int pulses;
    pulses = 0;
    drive(1, 4, 1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 1, 0);
      if (done_o === 1'b1) pulses++;
      n_checks++;
      if (count_o !== m_count || busy_o !== m_busy || done_o !== m_done)
        $display("FAIL auto_reload[%0d]: got %h/%b/%b, want %h/%b/%b", i, count_o, busy_o,
                 done_o, m_count, m_busy, m_done);
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 3 || busy_o !== 1'b1)
      $display("FAIL auto_reload_pulses: got %0d busy=%b, want 3 busy=1", pulses, busy_o);
    else n_pass++;
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_priority();
    drive(1, 3, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    // Load on the terminal edge restarts without a pulse.
    drive(1, 7, 1, 0, 0);
    n_checks++;
    if (count_o !== 7 || busy_o !== 1 || done_o !== 0)
      $display("FAIL prio_load: got %h/%b/%b, want 00000007/1/0", count_o, busy_o, done_o);
    else n_pass++;
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0);
    // Abort beats load and expiry.
    drive(1, 9, 1, 0, 1);
    n_checks++;
    if (count_o !== 0 || busy_o !== 0 || done_o !== 0)
      $display("FAIL prio_abort: got %h/%b/%b, want 0/0/0", count_o, busy_o, done_o);
    else n_pass++;
    // Enable in idle has no effect.
    drive(0, 0, 1, 1, 0);
    n_checks++;
    if (count_o !== m_count || busy_o !== m_busy || done_o !== m_done)
      $display("FAIL idle_enable: got %h/%b/%b, want %h/%b/%b", count_o, busy_o, done_o,
               m_count, m_busy, m_done);
    else n_pass++;
  endtask

  task automatic test_boundary();
    drive(1, 0, 1, 0, 0);
    n_checks++;
    if (count_o !== 0 || busy_o !== 0 || done_o !== 1)
      $display("FAIL zero_load: got %h/%b/%b, want 0/0/1", count_o, busy_o, done_o);
    else n_pass++;
    drive(0, 0, 1, 0, 0);
    n_checks++;
    if (done_o !== 0 || busy_o !== 0)
      $display("FAIL zero_load_after: got done=%b busy=%b, want 0/0", done_o, busy_o);
    else n_pass++;
    drive(1, 32'hFFFF_FFFF, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    n_checks++;
    if (count_o !== 32'hFFFF_FFFD || busy_o !== 1 || done_o !== 0)
      $display("FAIL max_load: got %h/%b/%b, want fffffffd/1/0", count_o, busy_o, done_o);
    else n_pass++;
    drive(0, 0, 0, 0, 1);
    // One-shot expiry leaves the count at zero rather than wrapping.
    drive(1, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    n_checks++;
    if (count_o !== 0 || busy_o !== 0 || done_o !== 0)
      $display("FAIL no_wrap: got %h/%b/%b, want 0/0/0", count_o, busy_o, done_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1, 2, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);  // expires here
    drive(1, 2, 1, 0, 0);  // reload in the done cycle
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (count_o !== m_count || busy_o !== m_busy || done_o !== m_done)
        $display("FAIL back_to_back[%0d]: got %h/%b/%b, want %h/%b/%b", i, count_o, busy_o,
                 done_o, m_count, m_busy, m_done);
      else n_pass++;
      drive(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_random();
    logic         l, e, a, ab;
    logic [W-1:0] v;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom % 8) == 0;
      v  = (($urandom % 10) == 0) ? W'($urandom) : W'($urandom % 7);
      e  = ($urandom % 4) != 0;
      a  = $urandom % 2;
      ab = ($urandom % 25) == 0;
      drive(l, v, e, a, ab);
      n_checks++;
      if (count_o !== m_count || busy_o !== m_busy || done_o !== m_done)
        $display("FAIL random[%0d]: got %h/%b/%b, want %h/%b/%b", i, count_o, busy_o,
                 done_o, m_count, m_busy, m_done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_pause();
    test_auto_reload();
    test_priority();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer_32.md
Name: countdown_timer_32

Overview:
- Loadable 32-bit down-counter/timer; the count-down complement to the free-running up-counter used for cycle counting.
- Used by control logic (multdiv sequencing, stall/timeout windows) to wait an exact number of enabled cycles and receive a single-cycle done pulse.
- Supports one-shot and auto-reload (periodic) modes, pause via enable, and abort.

Parameters:
- WIDTH, 32, counter and load-value width in bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- load  input  1  capture load_value and start; sampled on the rising clk edge.
- load_value  input  WIDTH  number of enabled cycles to count (unsigned).
- enable  input  1  1 = decrement this cycle while running; 0 = hold.
- auto_reload  input  1  1 = periodic mode: on expiry reload the captured value and keep running.
- abort  input  1  stop immediately; no done pulse.
- count  output  WIDTH  current remaining count, registered.
- busy  output  1  1 while in RUN, registered.
- done  output  1  one-cycle expiry pulse, registered.

Behaviour:
- Reset (reset=0, asynchronous): count=0, reload_reg=0, state=IDLE, busy=0, done=0. Outputs hold these values until the first rising edge after reset returns to 1.
- States: IDLE, RUN. busy=1 exactly when state=RUN.
- Per-edge priority: abort > load > terminal/decrement > hold.
- abort=1: count<=0, state<=IDLE, done<=0. Overrides a simultaneous load or expiry.
- load=1 with load_value!=0, in either state: count<=load_value, reload_reg<=load_value, state<=RUN, done<=0.
  - In RUN this restarts the timer; a terminal event on the same edge is discarded (no done).
- load=1 with load_value=0: count<=0, state<=IDLE, done<=1 for one cycle (zero-length timer expires immediately).
- RUN with enable=1 and count>1: count<=count-1.
- RUN with enable=1 and count==1 (terminal edge): done<=1 for one cycle.
  - auto_reload=0: count<=0, state<=IDLE.
  - auto_reload=1: count<=reload_reg, state stays RUN.
  - auto_reload is sampled on the terminal edge only.
- RUN with enable=0: count, state and reload_reg hold; done<=0.
- IDLE: enable has no effect; count holds. No wrap below 0; the count never wraps to all-ones.
- Latency: load V at edge E with enable held 1:
  - count=V after E.
  - done=1 during the cycle after edge E+V, the same cycle count first reads 0 (one-shot) or V again (reload).
  - Each enable=0 cycle delays done by one cycle.
- done is high for exactly one cycle per expiry and is 0 in every other cycle.
- Reset asserted mid-run: immediate return to reset values; no done pulse.
- Arithmetic: unsigned WIDTH-bit; load_value=2^WIDTH-1 is legal and counts the full range.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=1'b0, RUN=1'b1);
  - the default width constant (32);
  - a zero constant for the count compare.
- One natural sub-module: down_counter_core. It holds the count register with async active-low clear, parallel load, and decrement-by-enable, and flags count==1 combinationally.
- FSM, reload register and done logic live in the top module.

Test Plan:
- Reset: drive reset=0 mid-operation with count=0x10 -> count=0, busy=0, done=0 immediately, before any clk edge.
- One-shot: load_value=5, enable=1 -> count reads 5,4,3,2,1,0; done=1 only in the cycle count=0; busy falls the same cycle.
- Pause: load_value=3, enable pattern 1,0,0,1,1 -> count 3,2,2,2,1,0; done delayed by exactly 2 cycles versus continuous enable.
- Auto-reload: load_value=4, auto_reload=1, run 12 enabled cycles -> done pulses every 4th cycle (3 pulses), count sequence 4,3,2,1,4,3,2,1,4,...; busy stays 1.
- Priority: at count=1 assert load=1 with load_value=7 -> count=7, no done; at count=1 assert abort=1 with load=1 -> count=0, IDLE, no done.
- Boundaries: load_value=0 -> one-cycle done, busy stays 0. load_value=0xFFFFFFFF -> after 2 enabled cycles count=0xFFFFFFFD, with no wrap at expiry.
